// File: rtl/switch_debounce4.sv
// switch_debounce4: 2-flop synchronizer plus per-channel stable-count debouncer for four switches.
// Define SWITCH_DEBOUNCE4_PULSE_EN to add the sw_pulse rising-edge strobe output.
module switch_debounce4 #(
    parameter int CNT_MAX = 240000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw_in,
    output logic [3:0] sw_out
`ifdef SWITCH_DEBOUNCE4_PULSE_EN
    ,
    output logic [3:0] sw_pulse
`endif
);
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] LAST = CW'(CNT_MAX - 1);
    logic [3:0] meta, sync, done;
    logic [CW-1:0] cnt [4];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {sync, meta} <= '0;
        else {sync, meta} <= {meta, sw_in};
    always_comb
        for (int i = 0; i < 4; i++) done[i] = (sync[i] != sw_out[i]) && (cnt[i] == LAST);
    // a channel counts only while it disagrees with its accepted level
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sw_out <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            sw_out <= (sw_out & ~done) | (sync & done);
            for (int i = 0; i < 4; i++) cnt[i] <= (sync[i] == sw_out[i] || done[i]) ? '0 : cnt[i] + 1'b1;
        end
`ifdef SWITCH_DEBOUNCE4_PULSE_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sw_pulse <= '0;
        else sw_pulse <= done & sync;
`endif
endmodule

// File: tb/tb_switch_debounce4.sv
// tb_switch_debounce4: scoreboard bench; expected levels come from a sample-history acceptance model.
module tb_switch_debounce4;
    localparam int CNT_MAX = 8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] sw_in = 4'b0;
    logic [3:0] sw_out;
`ifdef SWITCH_DEBOUNCE4_PULSE_EN
    logic [3:0] sw_pulse;
`endif
    int errors = 0;
    int checks = 0;
    typedef struct { logic [3:0] o; logic [3:0] p; } exp_t;
    exp_t exp_q[$];
    logic [3:0] hq[$];
    logic [3:0] mo;
    int age[4];

    always #5 clk = ~clk;

    switch_debounce4 #(.CNT_MAX(CNT_MAX)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sw_in(sw_in),
        .sw_out(sw_out)
`ifdef SWITCH_DEBOUNCE4_PULSE_EN
        ,
        .sw_pulse(sw_pulse)
`endif
    );

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%b want=%b at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        hq.delete();
        repeat (CNT_MAX + 2) hq.push_back(4'b0);
        mo = 4'b0;
        for (int i = 0; i < 4; i++) age[i] = 1000;
    endtask

    // a level is accepted once the last CNT_MAX synchronized samples, all seen since the previous change, disagree with it
    task automatic model_edge(output exp_t e);
        e.p = 4'b0;
        if (!rst_n) begin
            model_reset();
        end else begin
            hq.push_front(sw_in);
            if (hq.size() > CNT_MAX + 2) void'(hq.pop_back());
            for (int i = 0; i < 4; i++) begin
                logic all_diff;
                all_diff = 1'b1;
                if (age[i] < 1000) age[i]++;
                for (int j = 2; j < CNT_MAX + 2; j++) if (hq[j][i] == mo[i]) all_diff = 1'b0;
                if (all_diff && age[i] >= CNT_MAX) begin
                    mo[i] = ~mo[i];
                    e.p[i] = mo[i];
                    age[i] = 0;
                end
            end
        end
        e.o = mo;
    endtask

    task automatic tick(input logic [3:0] v, input logic r, input string tag);
        exp_t e;
        @(negedge clk);
        sw_in = v;
        rst_n = r;
        model_edge(e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({tag, "_out"}, sw_out, e.o);
`ifdef SWITCH_DEBOUNCE4_PULSE_EN
        chk({tag, "_pulse"}, sw_pulse, e.p);
`endif
    endtask

    task automatic hold(input logic [3:0] v, input int n, input string tag);
        for (int k = 0; k < n; k++) tick(v, 1'b1, tag);
    endtask

    function automatic logic [3:0] cnt_or();
        return 4'(dut.cnt[0] | dut.cnt[1] | dut.cnt[2] | dut.cnt[3]);
    endfunction

    initial begin
        model_reset();
        #12;
        chk("rst_out", sw_out, 4'b0000);
        tick(4'b0000, 1'b0, "rst");
        tick(4'b0000, 1'b0, "rst");
        hold(4'b0000, 4, "idle");
        chk("idle_cnt", cnt_or(), 4'b0000);
        for (int k = 1; k <= 12; k++) begin
            tick(4'b0001, 1'b1, "step");
            if (k == 9) chk("step_e9", sw_out, 4'b0000);
            if (k == 10) chk("step_e10", sw_out, 4'b0001);
        end
        hold(4'b0101, 5, "short");
        hold(4'b0001, 12, "short_back");
        chk("short_cnt2", 4'(dut.cnt[2]), 4'b0000);
        chk("short_out", sw_out, 4'b0001);
        hold(4'b0011, 6, "bounce_hi");
        hold(4'b0001, 1, "bounce_lo");
        for (int k = 1; k <= 12; k++) begin
            tick(4'b0011, 1'b1, "bounce");
            if (k == 9) chk("bounce_e9", sw_out, 4'b0001);
            if (k == 10) chk("bounce_e10", sw_out, 4'b0011);
        end
        hold(4'b0000, 12, "clear");
        for (int k = 1; k <= 12; k++) begin
            tick(4'b1111, 1'b1, "all");
            if (k == 9) chk("all_e9", sw_out, 4'b0000);
            if (k == 10) chk("all_e10", sw_out, 4'b1111);
`ifdef SWITCH_DEBOUNCE4_PULSE_EN
            if (k == 10) chk("all_p10", sw_pulse, 4'b1111);
            if (k == 11) chk("all_p11", sw_pulse, 4'b0000);
`endif
        end
        for (int k = 1; k <= 12; k++) begin
            tick(4'b0000, 1'b1, "fall");
            if (k == 10) chk("fall_e10", sw_out, 4'b0000);
        end
        chk("fall_cnt", cnt_or(), 4'b0000);
        hold(4'b0111, 12, "pre");
        hold(4'b1111, 4, "cnt3");
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out", sw_out, 4'b0000);
        chk("midrst_cnt3", 4'(dut.cnt[3]), 4'b0000);
        model_reset();
        tick(4'b1111, 1'b0, "midrst");
        tick(4'b1111, 1'b0, "midrst");
        for (int k = 1; k <= 12; k++) begin
            tick(4'b1111, 1'b1, "rel");
            if (k == 9) chk("rel_e9", sw_out, 4'b0000);
            if (k == 10) chk("rel_e10", sw_out, 4'b1111);
`ifdef SWITCH_DEBOUNCE4_PULSE_EN
            if (k == 10) chk("rel_p10", sw_pulse, 4'b1111);
`endif
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
